// File: rtl/ex_muldiv_seq_if.sv
// ex_muldiv_seq_if: EX-stage handshake between the pipeline (master) and the
// iterative RV32M multiply/divide sequencer (slave).
interface ex_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, rs1, rs2, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, func3, rs1, rs2, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer beside the EX ALU.
// 32-step shift-add multiply or restoring divide on operand magnitudes, with
// sign fix-up applied when the result is presented.
// Optional: define MULDIV_EARLY_OUT_EN to skip iterations for multiply by zero
// and divide by zero.
module ex_muldiv_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic            clk,
    input logic            clr,
    ex_muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          func3_q, func3_d;
    logic [XLEN-1:0]     a_q, a_d;       // raw rs1, needed for REM by zero
    logic [XLEN-1:0]     b_q, b_d;       // multiplicand / divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;   // {hi, lo}: product, or {remainder, quotient}
    logic                neg_q, neg_d;   // product / quotient negate
    logic                rneg_q, rneg_d; // remainder negate
    logic                dz_q, dz_d;     // divisor was zero
    logic [XLEN-1:0]     result_q, result_d;

    logic              sgn_a, sgn_b, early;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quot, rem, final_res;

    // Operand sign handling and early-out detection at acceptance.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (bus.func3)
            3'd1, 3'd4, 3'd6: begin
                sgn_a = bus.rs1[XLEN-1];
                sgn_b = bus.rs2[XLEN-1];
            end
            3'd2:    sgn_a = bus.rs1[XLEN-1];
            default: ;
        endcase
        mag_a = sgn_a ? -bus.rs1 : bus.rs1;
        mag_b = sgn_b ? -bus.rs2 : bus.rs2;
`ifdef MULDIV_EARLY_OUT_EN
        early = bus.func3[2] ? (bus.rs2 == '0) : ((bus.rs1 == '0) || (bus.rs2 == '0));
`else
        early = 1'b0;
`endif
    end

    // One multiply or divide iteration, plus final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_sub   = XLEN'(div_shift - {1'b0, b_q});
        div_next  = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (func3_q)
            3'd0:             final_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = dz_q ? '1 : quot;
            default:          final_res = dz_q ? a_q : rem;
        endcase
    end

    // Next-state logic for the sequencer FSM and datapath registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.flush) begin
                    func3_d = bus.func3;
                    a_d     = bus.rs1;
                    b_d     = mag_b;
                    neg_d   = sgn_a ^ sgn_b;
                    rneg_d  = sgn_a;
                    dz_d    = (bus.rs2 == '0);
                    cnt_d   = '0;
                    // A skipped multiply must present a zero product.
                    acc_d   = (early && !bus.func3[2]) ? '0 : {{XLEN{1'b0}}, mag_a};
                    state_d = early ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = func3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!bus.flush) result_d = final_res;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            func3_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    // Pipeline-facing outputs; result is live in DONE so EX captures it that edge.
    always_comb begin
        bus.done   = (state_q == StDone) && !bus.flush;
        bus.busy   = (state_q == StCalc) || (state_q == StDone);
        bus.stall  = ((state_q == StIdle) && bus.start && !bus.flush) || (state_q == StCalc);
        bus.result = bus.done ? final_res : result_q;
    end
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed vector table plus hand sequences for flush,
// asynchronous reset and ignored start pulses.
module tb_ex_muldiv_seq;
    logic clk;
    logic clr;
    int   nchecks;
    int   nerr;

    ex_muldiv_seq_if #(.XLEN(32)) bus ();

    ex_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2] ? (b == 0) : (a == 0 || b == 0)) return 0;
`endif
        return 32;
    endfunction

    // Launch one op from an IDLE cycle and follow it through DONE.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int stall_bad;
        logic [31:0] res;
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.rs1   = a;
        bus.rs2   = b;
        #1;
        chk({name, " stall_accept"}, 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        // Inputs scrambled after acceptance must not matter.
        bus.start = 1'b0;
        bus.func3 = ~f3;
        bus.rs1   = ~a;
        bus.rs2   = ~b;
        lat = 0;
        stall_bad = 0;
        while (!bus.done && lat < 40) begin
            if (!bus.stall || !bus.busy) stall_bad++;
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        chk({name, " done_seen"}, 32'(bus.done), 32'd1);
        chk({name, " latency"}, 32'(lat), 32'(exp_latency(f3, a, b)));
        chk({name, " stall_calc"}, 32'(stall_bad), 32'd0);
        chk({name, " stall_done"}, 32'(bus.stall), 32'd0);
        chk({name, " result"}, res, exp);
        @(posedge clk); #1;
        chk({name, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, " result_hold"}, bus.result, exp);
        chk({name, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        nchecks = 0;
        nerr    = 0;
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        vecs[4]  = '{3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA};
        vecs[5]  = '{3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
        vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{3'd4, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFFF};
        vecs[11] = '{3'd6, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0};
        vecs[12] = '{3'd0, 32'd3,        32'd5,        32'd15};
        vecs[13] = '{3'd3, 32'h12345678, 32'd0,        32'd0};
        vecs[14] = '{3'd5, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF};

        clr       = 1'b0;
        bus.start = 1'b0;
        bus.func3 = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.flush = 1'b0;
        #12;
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset result", bus.result, 32'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // flush in IDLE blocks a simultaneous start
        bus.start = 1'b1;
        bus.func3 = 3'd5;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        bus.flush = 1'b1;
        #1;
        chk("flush_idle stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_idle busy", 32'(bus.busy), 32'd0);

        // DIVU aborted by flush at iteration 10
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        #1;
        chk("flush_calc stall", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        chk("flush result", bus.result, 32'hFFFFFFFF);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("flush no_done", 32'(pulses), 32'd0);

        // asynchronous reset at iteration 20
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        clr = 1'b0;
        #1;
        chk("clr busy", 32'(bus.busy), 32'd0);
        chk("clr done", 32'(bus.done), 32'd0);
        chk("clr stall", 32'(bus.stall), 32'd0);
        chk("clr result", bus.result, 32'd0);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        run_op("post_clr mul", 3'd0, 32'd3, 32'd5, 32'd15);

        // start pulses during CALC are ignored
        bus.start = 1'b1;
        bus.func3 = 3'd0;
        bus.rs1   = 32'd7;
        bus.rs2   = 32'hFFFFFFFA;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.func3 = 3'd5;
        bus.rs1   = 32'd100;
        bus.rs2   = 32'd7;
        lat = 0;
        while (!bus.done && lat < 40) begin
            bus.start = (lat == 5 || lat == 15);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk("ignore latency", 32'(lat), 32'd32);
        chk("ignore result", bus.result, 32'hFFFFFFD6);
        @(posedge clk); #1;
        run_op("after_done divu", 3'd5, 32'd100, 32'd7, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer attached beside the EX-stage ALU.
- When decode flags an M-extension op (func7 = 7'b0000001), this block latches rs1/rs2/func3, raises a pipeline stall, and runs a 32-step shift-add multiply or restoring divide.
- It then presents the 32-bit result for one cycle, which the EX result mux selects instead of the ALU result.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported).
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  reset, asynchronous, active-low.
- start  input  1  M-op present in EX; sampled only in IDLE.
- func3  input  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  input  32  operand A.
- rs2  input  32  operand B.
- flush  input  1  synchronous abort (branch/trap kill).
- stall  output  1  hold IF/ID/EX registers.
- busy  output  1  high in CALC or DONE.
- done  output  1  result valid, one-cycle pulse.
- result  output  32  operation result.

Behaviour:
- Reset (clr = 0, async): state = IDLE; counter, accumulator and latched operands = 0; done = 0, busy = 0, result = 0. Reset mid-operation discards all work and produces no done.
- States:
  - IDLE: on start = 1 and flush = 0, latch func3, rs1, rs2 and the operand signs. Load magnitudes: signed for MULH/DIV/REM, rs1-only signed for MULHSU, unsigned otherwise. Set counter = 0 and go to CALC.
  - CALC: one iteration per edge, counter += 1. At the edge where counter == 31, go to DONE.
  - DONE: done = 1, result valid. Next edge returns to IDLE.
- Latency: start accepted at edge E0; 32 iterations at E1..E32; done high in the cycle after E32.
- stall = (IDLE & start & ~flush) | CALC. stall is low in DONE so the pipeline advances and captures result on the same edge.
- Multiply:
  - 64-bit unsigned product of the magnitudes.
  - Negate the product if the sign flags differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring divide on 33-bit partial remainder, magnitudes only.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Divide by zero (rs2 = 0) is forced regardless of sign:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU remainder = rs1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives DIV = 0x80000000, REM = 0.
- result holds its value after DONE until the next completion.
- start while busy is ignored. No queuing; operands are not re-sampled.
- flush in CALC or DONE: return to IDLE next edge, done stays 0, result unchanged. flush in IDLE blocks acceptance of a simultaneous start.
- func3 and operands are captured at acceptance; later input changes have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: at acceptance, if (multiply and either operand = 0) or (divide and rs2 = 0), skip CALC and go IDLE -> DONE directly.
  - done is high in the cycle after E0.
  - stall is high only during the accept cycle.
  - result equals the normal-path value.
- Undefined: every operation takes the full 32 iterations; done always in the cycle after E32.

Test Plan:
- MUL, rs1 = 7, rs2 = 0xFFFFFFFA (-6): result = 0xFFFFFFD6; done exactly in the cycle after the 32nd iteration edge; stall high in the start cycle and 32 CALC cycles, low in DONE.
- MULH, rs1 = rs2 = 0x80000000: result = 0x40000000. MULHU, rs1 = rs2 = 0xFFFFFFFF: result = 0xFFFFFFFE. MULHSU, rs1 = 0xFFFFFFFF, rs2 = 2: result = 0xFFFFFFFF.
- DIV, rs1 = 0xFFFFFFEC (-20), rs2 = 3: result = 0xFFFFFFFA. REM same operands: 0xFFFFFFFE. DIVU, rs1 = 100, rs2 = 7: 14. REMU same operands: 2.
- DIV, rs1 = 0x80000000, rs2 = 0xFFFFFFFF: result 0x80000000, and REM gives 0. DIV by 0 with rs1 = 0xFFFFFFF0: result 0xFFFFFFFF, and REM gives 0xFFFFFFF0. With MULDIV_EARLY_OUT_EN, the divide-by-zero done arrives one cycle after start.
- Start DIVU, assert flush at iteration 10: state IDLE next edge, no done pulse, result unchanged. Assert clr at iteration 20: all outputs 0 immediately; a fresh MUL 3 x 5 then completes with result = 15.
- Second start pulses during CALC are ignored; the first op's result is delivered, and a new start in the cycle after DONE is accepted normally.
